// File: rtl/load_store_controller_pkg.sv
// load_store_controller_pkg: shared opcodes, FSM state encodings and instruction field positions
package load_store_controller_pkg;
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_ZERO  = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam int OP_HI   = 7;
    localparam int OP_LO   = 6;
    localparam int REG_HI  = 5;
    localparam int REG_LO  = 4;
    localparam int RSV_BIT = 3;
    localparam int ADDR_HI = 2;
    localparam int ADDR_LO = 0;
endpackage

// File: rtl/load_store_controller_regfile.sv
// ls_regfile: NREGS x DATA_W register file, one sync write port, two comb read ports
//   clk/clr        clock, synchronous active-high clear of all registers
//   we/waddr/wdata write port
//   raddr/rdata    store-data read port
//   oaddr/odata    observation read port
module ls_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [RW-1:0]     oaddr,
    output logic [DATA_W-1:0] odata
);
    logic [DATA_W-1:0] regs [NREGS];
    always_ff @(posedge clk) begin
        if (clr) regs <= '{default: '0};
        else if (we) regs[waddr] <= wdata;
    end
    assign rdata = regs[raddr];
    assign odata = regs[oaddr];
endmodule

// File: rtl/load_store_controller.sv
// load_store_controller: one-at-a-time load/store initiator driving dataMemory strobes
//   clk/clr                     clock, synchronous active-high reset
//   instr/instr_valid/ready     instruction handshake ([7:6] op, [5:4] reg, [2:0] addr)
//   busy/done                   in-flight flag, one-cycle completion pulse
//   mem_en/rd_en/wr_en/addr/wdata  registered memory strobes; mem_rdata comb read data
//   obs_sel/obs_data            register-file observation port
module load_store_controller
    import load_store_controller_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        obs_sel,
    output logic [DATA_W-1:0] obs_data
);
    localparam int RW = $clog2(NREGS);
    state_t            state, state_n;
    op_t               op, iop;
    logic [RW-1:0]     r;
    logic [DATA_W-1:0] sdata;
    logic              launch, ld_n, st_n, done_n, we;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n, rf_wdata;
    assign instr_ready = state == S_IDLE && !clr;
    assign busy        = state != S_IDLE;
    assign iop         = op_t'(instr[OP_HI:OP_LO]);
    // Strobes for EXEC are decoded at the accept edge so they come straight from flops.
    always_comb begin
        launch  = state == S_IDLE && instr_valid;
        state_n = state == S_IDLE ? (instr_valid ? S_EXEC : S_IDLE)
                : state == S_EXEC ? S_DONE : S_IDLE;
        ld_n    = launch && iop == OP_LOAD;
        st_n    = launch && iop == OP_STORE;
        addr_n  = (ld_n || st_n) ? instr[ADDR_HI:ADDR_LO] : '0;
        wdata_n = st_n ? sdata : '0;
        done_n  = state == S_EXEC;
    end
    always_ff @(posedge clk) begin
        state <= clr ? S_IDLE : state_n;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_en    <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            op        <= OP_NOP;
            r         <= '0;
        end else begin
            mem_en    <= ld_n || st_n;
            mem_rd_en <= ld_n;
            mem_wr_en <= st_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            done      <= done_n;
            if (launch) begin
                op <= iop;
                r  <= instr[REG_HI:REG_LO];
            end
        end
    end
    assign we       = state == S_EXEC && !clr && (op == OP_LOAD || op == OP_ZERO);
    assign rf_wdata = op == OP_LOAD ? mem_rdata : '0;
    ls_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .clr   (clr),
        .we    (we),
        .waddr (r),
        .wdata (rf_wdata),
        .raddr (instr[REG_HI:REG_LO]),
        .rdata (sdata),
        .oaddr (obs_sel),
        .odata (obs_data)
    );
endmodule

// File: tb/tb_load_store_controller.sv
// tb_load_store_controller: directed stimulus with a cycle-level behavioural model and memory
module tb_load_store_controller;
    logic       clk = 0, clr = 1, instr_valid = 0;
    logic [7:0] instr = 0;
    logic [1:0] obs_sel = 0;
    logic       instr_ready, busy, done, mem_en, mem_rd_en, mem_wr_en;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata, obs_data;
    logic [7:0] mem  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA7, 8'h00, 8'h00};
    logic [7:0] mmem [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA7, 8'h00, 8'h00};
    logic [7:0] m_reg [4] = '{default: 8'h00};
    logic [1:0] m_op = 0, m_r = 0;
    logic [2:0] m_a = 0;
    logic [7:0] m_sd = 0;
    int age = 0, en = 0, errors = 0, checks = 0;
    int cyc_n = 0, acc = 0, dcnt = 0, last_done = 0, gap = 0;

    always #5 clk = ~clk;

    load_store_controller dut (
        .clk(clk), .clr(clr), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .done(done), .mem_en(mem_en),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .obs_sel(obs_sel), .obs_data(obs_data)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_en && mem_wr_en) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: age counts cycles since accept (0 idle, 1 strobe cycle, 2 done cycle).
    always @(posedge clk) begin
        cyc_n++;
        if (instr_ready && instr_valid) acc++;
        if (age == 1 && m_op == 2'b10) mmem[m_a] = m_sd;
        if (clr) begin
            age = 0;
            en = 1;
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
        end else if (age == 0) begin
            if (instr_valid) begin
                m_op = instr[7:6];
                m_r  = instr[5:4];
                m_a  = instr[2:0];
                m_sd = m_reg[instr[5:4]];
                age  = 1;
            end
        end else if (age == 1) begin
            if (m_op == 2'b01) m_reg[m_r] = mmem[m_a];
            if (m_op == 2'b11) m_reg[m_r] = 0;
            age = 2;
        end else age = 0;
    end

    always @(negedge clk) begin
        if (done) begin
            dcnt++;
            gap = cyc_n - last_done;
            last_done = cyc_n;
        end
        if (en != 0) begin
            logic ld, st;
            ld = age == 1 && m_op == 2'b01;
            st = age == 1 && m_op == 2'b10;
            chk("instr_ready", instr_ready, age == 0 && !clr);
            chk("busy", busy, age != 0);
            chk("done", done, age == 2);
            chk("mem_en", mem_en, ld || st);
            chk("mem_rd_en", mem_rd_en, ld);
            chk("mem_wr_en", mem_wr_en, st);
            chk("mem_addr", mem_addr, (ld || st) ? m_a : 3'd0);
            chk("mem_wdata", mem_wdata, st ? m_sd : 8'd0);
            chk("obs_data", obs_data, m_reg[obs_sel]);
            for (int i = 0; i < 8; i++) chk("mem_contents", mem[i], mmem[i]);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [7:0] v);
        instr = v;
        instr_valid = 1;
        cyc();
        instr_valid = 0;
    endtask

    initial begin
        int a0, d0;
        cyc(2);
        clr = 0;
        cyc(3);
        clr = 1;
        cyc(2);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready_in_clr", instr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            obs_sel = 2'(i);
            #1 chk("rst_obs", obs_data, 0);
        end
        clr = 0;
        #1 chk("ready_after_clr", instr_ready, 1);
        issue(8'h65);
        chk("load_rd_en", mem_rd_en, 1);
        chk("load_addr", mem_addr, 5);
        cyc();
        chk("load_done", done, 1);
        obs_sel = 2;
        #1 chk("load_obs_r2", obs_data, 8'hA7);
        cyc();
        issue(8'hA3);
        chk("store_wr_en", mem_wr_en, 1);
        chk("store_addr", mem_addr, 3);
        chk("store_wdata", mem_wdata, 8'hA7);
        cyc(2);
        chk("store_mem3", mem[3], 8'hA7);
        a0 = acc;
        d0 = dcnt;
        instr = 8'h65;
        instr_valid = 1;
        cyc(6);
        instr_valid = 0;
        cyc(3);
        chk("hold_accepts", acc - a0, 2);
        chk("hold_dones", dcnt - d0, 2);
        chk("hold_done_gap", gap, 3);
        issue(8'h00);
        chk("nop_no_en", mem_en, 0);
        cyc();
        chk("nop_done", done, 1);
        cyc();
        issue(8'hE0);
        chk("zero_no_en", mem_en, 0);
        cyc();
        obs_sel = 2;
        #1 chk("zero_obs_r2", obs_data, 0);
        cyc();
        issue(8'h5D);
        chk("rsv_addr", mem_addr, 5);
        cyc();
        obs_sel = 1;
        #1 chk("rsv_obs_r1", obs_data, 8'hA7);
        cyc();
        issue(8'h65);
        cyc(2);
        issue(8'hA3);
        chk("abort_pre_wr", mem_wr_en, 1);
        d0 = dcnt;
        clr = 1;
        cyc();
        chk("abort_wr", mem_wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        clr = 0;
        cyc(3);
        chk("abort_no_done", dcnt - d0, 0);
        chk("abort_mem_en", mem_en, 0);
        for (int i = 0; i < 4; i++) begin
            obs_sel = 2'(i);
            #1 chk("abort_obs", obs_data, 0);
        end
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Initiator side of the data-memory interface: accepts one load/store instruction at a time over a valid/ready handshake.
- Drives the memory-side strobes (en, read_en_global, write_en_global, address, write data) and captures read data into a small internal register file.
- Sits between the instruction source and dataMemory in the LoadStoreMachine.
- Its register file supplies the store data and receives the load results.

Parameters:
- DATA_W, 8, data word width; matches the memory word.
- ADDR_W, 3, memory address width (8 locations).
- NREGS, 4, number of internal registers. Register index width is log2(NREGS) = 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- instr  input  8  [7:6] op, [5:4] reg index, [3] reserved (ignored), [2:0] memory address.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  controller accepts instr this cycle.
- busy  output  1  an instruction is in flight.
- done  output  1  one-cycle pulse when an instruction completes.
- mem_en  output  1  memory decoder enable.
- mem_rd_en  output  1  to read_en_global.
- mem_wr_en  output  1  to write_en_global.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; combinational from mem_addr/mem_rd_en.
- obs_sel  input  2  register-file observation select.
- obs_data  output  DATA_W  combinational read of reg[obs_sel].

Behaviour:
- Opcodes:
  - 00 NOP
  - 01 LOAD: reg[r] <= mem[a]
  - 10 STORE: mem[a] <= reg[r]
  - 11 ZERO: reg[r] <= 0, no memory access.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: instr_ready=1. On instr_valid=1, latch op, r and a; go to EXEC. Otherwise stay in IDLE.
  - EXEC: exactly one cycle. Strobes are driven per op (table below).
  - DONE: exactly one cycle; done=1. Always returns to IDLE.
- EXEC strobe table:
  - LOAD: mem_en=1, mem_rd_en=1, mem_addr=a.
  - STORE: mem_en=1, mem_wr_en=1, mem_addr=a, mem_wdata=reg[r] as latched at accept.
  - NOP and ZERO: all strobes 0.
- Register update at the edge ending EXEC:
  - LOAD: reg[r] <= mem_rdata.
  - ZERO: reg[r] <= 0.
- Latency: accept at cycle N, strobes in N+1, done and updated register visible on obs_data in N+2, instr_ready high again in N+3.
- Throughput is one instruction per 3 cycles. instr_ready is low in EXEC and DONE; instr_valid is ignored in those states. Holding the same instr is not a second accept until IDLE.
- busy=1 in EXEC and DONE.
- All mem_* outputs and done are registered (decoded into flops on the state transition), so they are glitch-free.
- mem_addr and mem_wdata are 0 whenever their strobe is 0.
- STORE data is reg[r] sampled at the accept edge. A LOAD followed by a STORE of the same register stores the loaded value, because the LOAD completes first.
- Reserved bit [3] has no effect.
- Reset (clr=1, sampled at an edge):
  - state=IDLE; all regs=0.
  - mem_en, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, busy = 0; instr_ready=0 while clr is high.
  - clr during EXEC aborts: strobes drop at that edge, no register update, no done pulse.
  - A write strobe already present in the cycle clr rises is not retracted. The memory sees it at that same edge, since the memory shares clk/clr.

Decomposition:
- Shared package / include holds:
  - opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_ZERO.
  - state encodings S_IDLE, S_EXEC, S_DONE.
  - instruction field bit positions.
- One natural sub-module: ls_regfile. NREGS x DATA_W, one synchronous write port (we, waddr, wdata, synchronous clr) and two combinational read ports (store data, observation).
- The FSM and strobe registers stay in the top module.

Test Plan:
- Reset: assert clr 2 cycles mid-idle -> all outputs 0, obs_data=0 for obs_sel 0..3, instr_ready=1 the cycle after clr drops.
- ZERO/LOAD round trip: preload mem[5]=0xA7 via bench; LOAD r2,5 (instr=0x65) -> mem_rd_en=1 and mem_addr=5 exactly 1 cycle after accept; done 2 cycles after accept; obs_sel=2 gives 0xA7.
- STORE: after the LOAD above, STORE r2,3 (instr=0xA3) -> one-cycle mem_wr_en with mem_addr=3 and mem_wdata=0xA7; memory location 3 reads 0xA7 afterwards.
- Handshake: hold instr_valid high with 0x65 for 6 cycles -> exactly two accepts, two done pulses 3 cycles apart; no accept in EXEC or DONE.
- NOP/ZERO: NOP (0x00) -> done after 2 cycles, no strobes; ZERO r2 (0xE0) -> obs_data for r2 becomes 0x00, no strobes.
- Abort: issue STORE r2,3, then assert clr in the EXEC cycle -> no done pulse; state back to IDLE; regs 0; no write strobe after the clr edge.
